// File: rtl/inst_fetch_pair_pkg.sv
// inst_fetch_pair_pkg: shared widths, fetch FSM states and issue-mask encodings.
package inst_fetch_pair_pkg;
  localparam int FETCH_W = 64;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OFFER, S_DROP} state_e;
  localparam logic [1:0] ISSUE_NONE = 2'b00;
  localparam logic [1:0] ISSUE_IN2  = 2'b01;
  localparam logic [1:0] ISSUE_IN1  = 2'b10;
  localparam logic [1:0] ISSUE_BOTH = 2'b11;
endpackage

// File: rtl/inst_fetch_pair_slot_pack.sv
// inst_fetch_pair_slot_pack: maps a fetched pair onto the in1/in2 slots and issue mask.
module inst_fetch_pair_slot_pack
  import inst_fetch_pair_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int INST_W = 32
)(
  input  logic [PC_W-1:0]     pc_i,
  input  logic [2*INST_W-1:0] rdata_i,
  input  logic                hi_only_i,
  output logic [INST_W-1:0]   in1_inst_o,
  output logic [PC_W-1:0]     in1_pc_o,
  output logic [PC_W-1:0]     in1_npc_o,
  output logic [INST_W-1:0]   in2_inst_o,
  output logic [PC_W-1:0]     in2_pc_o,
  output logic [PC_W-1:0]     in2_npc_o,
  output logic [1:0]          issue_o
);
  // An unaligned target skips the low word, so only slot 2 carries an instruction.
  assign in1_inst_o = hi_only_i ? '0 : rdata_i[INST_W-1:0];
  assign in1_pc_o   = hi_only_i ? '0 : pc_i;
  assign in1_npc_o  = hi_only_i ? '0 : pc_i + PC_W'(4);
  assign in2_inst_o = rdata_i[2*INST_W-1:INST_W];
  assign in2_pc_o   = hi_only_i ? pc_i : pc_i + PC_W'(4);
  assign in2_npc_o  = in2_pc_o + PC_W'(4);
  assign issue_o    = hi_only_i ? ISSUE_IN2 : ISSUE_BOTH;
endmodule

// File: rtl/inst_fetch_pair.sv
// inst_fetch_pair: dual-issue fetch stage issuing 8-byte pair requests and offering
// up to two instructions to the IF/ID buffer, with backpressure and branch flush.
module inst_fetch_pair
  import inst_fetch_pair_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int INST_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                branch_flag,
  input  logic [PC_W-1:0]     branch_target,
  input  logic                instbuf_full,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_rvalid,
  input  logic [2*INST_W-1:0] imem_rdata,
  output logic [1:0]          issue,
  output logic [INST_W-1:0]   in1_inst,
  output logic [PC_W-1:0]     in1_pc,
  output logic [PC_W-1:0]     in1_npc,
  output logic [INST_W-1:0]   in2_inst,
  output logic [PC_W-1:0]     in2_pc,
  output logic [PC_W-1:0]     in2_npc,
  output logic                stop
);
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0] issue_q, issue_d;
  logic capture;
  logic [INST_W-1:0] in1_inst_q, in2_inst_q, pk_in1_inst, pk_in2_inst;
  logic [PC_W-1:0] in1_pc_q, in1_npc_q, in2_pc_q, in2_npc_q;
  logic [PC_W-1:0] pk_in1_pc, pk_in1_npc, pk_in2_pc, pk_in2_npc;
  logic [1:0] pk_issue;
  logic [PC_W-1:0] pair_pc;

  assign pair_pc = {pc_q[PC_W-1:3], 3'b000};

  inst_fetch_pair_slot_pack #(.PC_W(PC_W), .INST_W(INST_W)) u_pack (
    .pc_i(pc_q), .rdata_i(imem_rdata), .hi_only_i(pc_q[2]),
    .in1_inst_o(pk_in1_inst), .in1_pc_o(pk_in1_pc), .in1_npc_o(pk_in1_npc),
    .in2_inst_o(pk_in2_inst), .in2_pc_o(pk_in2_pc), .in2_npc_o(pk_in2_npc),
    .issue_o(pk_issue)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    issue_d = issue_q;
    capture = 1'b0;
    if (branch_flag) begin
      pc_d    = branch_target;
      issue_d = ISSUE_NONE;
      state_d = ((state_q == S_WAIT || state_q == S_DROP) && !imem_rvalid) ? S_DROP : S_REQ;
    end else begin
      case (state_q)
        S_REQ:   state_d = S_WAIT;
        S_WAIT: if (imem_rvalid) begin
          capture = 1'b1;
          issue_d = pk_issue;
          state_d = S_OFFER;
        end
        S_OFFER: if (!instbuf_full) begin
          issue_d = ISSUE_NONE;
          pc_d    = pair_pc + PC_W'(8);
          state_d = S_REQ;
        end
        default: state_d = imem_rvalid ? S_REQ : S_DROP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      issue_q    <= ISSUE_NONE;
      in1_inst_q <= '0;
      in1_pc_q   <= '0;
      in1_npc_q  <= '0;
      in2_inst_q <= '0;
      in2_pc_q   <= '0;
      in2_npc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      issue_q <= issue_d;
      if (capture) begin
        in1_inst_q <= pk_in1_inst;
        in1_pc_q   <= pk_in1_pc;
        in1_npc_q  <= pk_in1_npc;
        in2_inst_q <= pk_in2_inst;
        in2_pc_q   <= pk_in2_pc;
        in2_npc_q  <= pk_in2_npc;
      end
    end
  end

  // A redirect in the request cycle suppresses the strobe so no orphan request is left owed.
  assign imem_req  = !rst && state_q == S_REQ && !branch_flag;
  assign imem_addr = imem_req ? pair_pc : '0;
  assign issue     = issue_q;
  assign stop      = !rst && issue_q == ISSUE_NONE;
  assign in1_inst  = in1_inst_q;
  assign in1_pc    = in1_pc_q;
  assign in1_npc   = in1_npc_q;
  assign in2_inst  = in2_inst_q;
  assign in2_pc    = in2_pc_q;
  assign in2_npc   = in2_npc_q;
endmodule

// File: tb/tb_inst_fetch_pair.sv
// tb_inst_fetch_pair: directed and random checks of the fetch stage against a
// transaction-level model of requests, owed responses and offered slots.
module tb_inst_fetch_pair;
  import inst_fetch_pair_pkg::*;
  logic clk, rst, branch_flag, instbuf_full, imem_req, imem_rvalid, stop;
  logic [31:0] branch_target, imem_addr, in1_inst, in1_pc, in1_npc, in2_inst, in2_pc, in2_npc;
  logic [FETCH_W-1:0] imem_rdata;
  logic [1:0] issue;

  inst_fetch_pair #(.PC_W(32), .INST_W(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .branch_flag(branch_flag), .branch_target(branch_target),
    .instbuf_full(instbuf_full), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .issue(issue),
    .in1_inst(in1_inst), .in1_pc(in1_pc), .in1_npc(in1_npc),
    .in2_inst(in2_inst), .in2_pc(in2_pc), .in2_npc(in2_npc), .stop(stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [31:0] exp_pc, e1i, e1p, e1n, e2i, e2p, e2n, pa, last_addr;
  logic [1:0] exp_issue;
  logic owed, live, pend, seen_req;
  int cnt;

  function automatic logic [31:0] w(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_C0DE;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc = 32'h100; exp_issue = 2'b00;
    owed = 1'b0; live = 1'b0; pend = 1'b0; cnt = 0; seen_req = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic cyc(input logic bf, input logic [31:0] bt, input logic fl, input int lat);
    logic rv;
    rv = 1'b0;
    if (pend) begin
      if (cnt == 1) begin rv = 1'b1; pend = 1'b0; end
      else cnt--;
    end
    branch_flag = bf; branch_target = bt; instbuf_full = fl; imem_rvalid = rv;
    imem_rdata = rv ? {w(pa + 4), w(pa)} : {w(32'hDEAD_0004), w(32'hDEAD_0000)};
    #1;
    chk("req", imem_req, !owed && exp_issue == 2'b00 && !bf);
    seen_req = imem_req;
    if (imem_req) begin
      chk("addr", imem_addr, {exp_pc[31:3], 3'b000});
      last_addr = imem_addr;
    end
    chk("issue", issue, exp_issue);
    chk("stop", stop, exp_issue == 2'b00);
    if (exp_issue != 2'b00) begin
      chk("in1", {in1_inst, in1_pc}, {e1i, e1p});
      chk("in1_npc", in1_npc, e1n);
      chk("in2", {in2_inst, in2_pc}, {e2i, e2p});
      chk("in2_npc", in2_npc, e2n);
    end
    if (bf) begin
      exp_pc = bt; exp_issue = 2'b00; live = 1'b0;
    end else if (exp_issue != 2'b00 && !fl) begin
      exp_pc = {exp_pc[31:3], 3'b000} + 32'd8; exp_issue = 2'b00;
    end else if (rv && live) begin
      live = 1'b0;
      if (!exp_pc[2]) begin
        e1i = w(pa); e1p = exp_pc; e1n = exp_pc + 4;
        e2i = w(pa + 4); e2p = exp_pc + 4; e2n = exp_pc + 8; exp_issue = 2'b11;
      end else begin
        e1i = 0; e1p = 0; e1n = 0;
        e2i = w(pa + 4); e2p = exp_pc; e2n = exp_pc + 4; exp_issue = 2'b01;
      end
    end
    if (rv) owed = 1'b0;
    if (imem_req) begin owed = 1'b1; live = 1'b1; pend = 1'b1; cnt = lat; pa = imem_addr; end
    @(posedge clk); #1;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (issue == 2'b00 && n < 20) begin cyc(1'b0, 32'h0, 1'b0, 1); n++; end
    chk("wait_issue_bound", issue != 2'b00, 1);
  endtask

  task automatic wait_req();
    int n = 0;
    seen_req = 1'b0;
    while (!seen_req && n < 20) begin cyc(1'b0, 32'h0, 1'b0, 1); n++; end
    chk("wait_req_bound", seen_req, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {imem_req, imem_addr, issue, stop}, 0);
    chk({tag, "_in1"}, {in1_inst, in1_pc}, 0);
    chk({tag, "_in2"}, {in2_inst, in2_pc}, 0);
    chk({tag, "_npc"}, {in1_npc, in2_npc}, 0);
  endtask

  initial begin
    rst = 1'b1; branch_flag = 1'b0; branch_target = '0; instbuf_full = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; last_addr = '0; pa = '0;
    e1i = 0; e1p = 0; e1n = 0; e2i = 0; e2p = 0; e2n = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk_reset_outputs("reset0");
    rst = 1'b0;
    // Sequential fetch with one-cycle memory, first offer held by a full buffer.
    cyc(1'b0, 32'h0, 1'b0, 1);
    chk("addr_100", last_addr, 32'h100);
    cyc(1'b0, 32'h0, 1'b0, 1);
    chk("offer0_issue", issue, 2'b11);
    chk("offer0_pcs", {in1_pc, in2_pc}, {32'h100, 32'h104});
    chk("offer0_npc", in2_npc, 32'h108);
    repeat (5) cyc(1'b0, 32'h0, 1'b1, 1);
    cyc(1'b0, 32'h0, 1'b0, 1);
    cyc(1'b0, 32'h0, 1'b0, 1);
    chk("req_after_full", {31'h0, seen_req, last_addr}, {32'h1, 32'h108});
    cyc(1'b0, 32'h0, 1'b0, 1);
    cyc(1'b0, 32'h0, 1'b0, 1);
    cyc(1'b0, 32'h0, 1'b0, 1);
    chk("addr_110", last_addr, 32'h110);
    // Redirect to an unaligned target while waiting on a slow response.
    cyc(1'b0, 32'h0, 1'b0, 1);
    cyc(1'b0, 32'h0, 1'b0, 1);
    cyc(1'b0, 32'h0, 1'b0, 3);
    chk("addr_118", last_addr, 32'h118);
    cyc(1'b1, 32'h204, 1'b0, 1);
    wait_req();
    chk("addr_200", last_addr, 32'h200);
    wait_issue();
    chk("unaligned_issue", issue, 2'b01);
    chk("unaligned_in2", {in2_pc, in2_npc}, {32'h204, 32'h208});
    chk("unaligned_in1", {in1_inst, in1_pc}, 0);
    // Redirect on a handover edge cancels that handover.
    cyc(1'b1, 32'h300, 1'b0, 1);
    chk("flush_issue", issue, 2'b00);
    wait_req();
    chk("addr_300", last_addr, 32'h300);
    // Asynchronous reset while a response is owed; the late response is ignored.
    rst = 1'b1;
    #1;
    chk_reset_outputs("reset_mid");
    imem_rvalid = 1'b1; imem_rdata = {w(32'h304), w(32'h300)};
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    chk_reset_outputs("reset_rv");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cyc(1'b0, 32'h0, 1'b0, 1);
    chk("addr_after_reset", {31'h0, seen_req, last_addr}, {32'h1, 32'h100});
    // PC wrap at the top of the address space.
    wait_issue();
    cyc(1'b1, 32'hFFFF_FFF8, 1'b0, 1);
    wait_issue();
    chk("wrap_in2", {in2_pc, in2_npc}, {32'hFFFF_FFFC, 32'h0});
    cyc(1'b0, 32'h0, 1'b0, 1);
    cyc(1'b0, 32'h0, 1'b0, 1);
    chk("wrap_addr", {31'h0, seen_req, last_addr}, {32'h1, 32'h0});
    // Random redirects, backpressure and memory latency.
    for (int i = 0; i < 400; i++) begin
      logic bf, fl;
      logic [31:0] bt;
      bf = ($urandom_range(0, 19) == 0);
      bt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2)) : ($urandom & ~32'h3);
      fl = ($urandom_range(0, 2) == 0);
      cyc(bf, bt, fl, $urandom_range(1, 3));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inst_fetch_pair.md
Name: inst_fetch_pair

Overview:
Dual-issue fetch stage: the producer side of the IF→ID instruction buffer. Keeps the fetch PC and issues 8-byte-aligned pair requests to instruction memory, which may take several cycles to respond. Presents up to two instructions per handover as in1/in2 with pc/npc and a 2-bit issue mask. Honours the buffer's full backpressure and discards in-flight work on a branch redirect.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bit [1:0] must be 0.
PC_W, 32, PC width; matches `PC_BUS.
INST_W, 32, instruction width; matches `INST_BUS.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
branch_flag  in  1  redirect from execute; flush and restart at branch_target.
branch_target  in  PC_W  redirect PC; bit [1:0] = 0.
instbuf_full  in  1  buffer cannot accept this cycle.
imem_req  out  1  memory request strobe, one cycle per request.
imem_addr  out  PC_W  pair address; bits [2:0] always 0.
imem_rvalid  in  1  read data valid, exactly once per request.
imem_rdata  in  2*INST_W  [31:0] = word at addr, [63:32] = word at addr+4.
issue  out  2  bit1: in1 valid, bit0: in2 valid; 00 = nothing offered.
in1_inst/in1_pc/in1_npc  out  INST_W/PC_W/PC_W  slot-1 instruction, its PC, and PC+4.
in2_inst/in2_pc/in2_npc  out  INST_W/PC_W/PC_W  slot-2 instruction, its PC, and PC+4.
stop  out  1  = (issue == 2'b00); tells the buffer not to load.

Behaviour:
- Reset (async, any state, including mid-request): fetch_pc = RESET_PC; state = S_REQ; all outputs 0. Any imem_rvalid still owed is ignored until the next request is issued.
- Only one request is outstanding at a time. Handover = rising edge with issue != 00 and instbuf_full == 0.
- Per-state actions:
  - S_REQ: imem_req = 1 and imem_addr = {fetch_pc[PC_W-1:3], 3'b000} for one cycle. Next state is S_WAIT.
  - S_WAIT: wait for imem_rvalid. On rvalid, register the slots (rules below), drive issue, and go to S_OFFER. Data is visible the cycle after rvalid.
  - S_OFFER: hold all in*/issue stable. On handover, clear issue, set fetch_pc = {fetch_pc[PC_W-1:3], 3'b000} + 8, and go to S_REQ.
  - S_DROP: waiting for the rvalid of a flushed request. On rvalid, discard the data and go to S_REQ (fetch_pc already holds the target).
- Slot rules on capture:
  - fetch_pc[2] = 0: in1 = rdata[31:0], in2 = rdata[63:32]; in1_pc = fetch_pc, in2_pc = fetch_pc + 4; issue = 11.
  - fetch_pc[2] = 1 (unaligned target): in1 fields = 0; in2 = rdata[63:32], in2_pc = fetch_pc; issue = 01.
  - inN_npc = inN_pc + 4, wrapping modulo 2^PC_W.
- branch_flag (highest priority; the same-cycle handover is cancelled):
  - fetch_pc = branch_target; issue = 00 next cycle.
  - From S_WAIT with no rvalid that cycle: go to S_DROP.
  - Otherwise, including rvalid in the same cycle: drop the data and go to S_REQ.
- instbuf_full held high indefinitely: stay in S_OFFER with outputs frozen. No new request is issued.
- PC wrap: 0xFFFF_FFF8 + 8 = 0x0000_0000, with no error.
- Throughput with zero-wait memory and a non-full buffer: one pair every 3 cycles (REQ → WAIT → OFFER).

Decomposition:
- Shared def.vh gains `FETCH_W` (= 2*INST_W), the state encodings S_REQ/S_WAIT/S_OFFER/S_DROP, and the ISSUE_* constants (00/01/10/11) so the buffer and fetch stage agree.
- One sub-module is natural: fetch_slot_pack. It is combinational and maps fetch_pc, rdata and the alignment bit to the in1/in2 fields and the issue mask.

Test Plan:
- Reset with RESET_PC = 0x100, memory responding 1 cycle after each request → imem_addr sequence 0x100, 0x108, 0x110; each offer has issue = 11, in1_pc = 0x100, in2_pc = 0x104, in2_npc = 0x108, and so on.
- instbuf_full held high for 5 cycles during S_OFFER → all in*/issue unchanged and imem_req stays 0. One cycle after full drops, imem_req = 1 with addr 0x108.
- branch_flag with target 0x204 while in S_WAIT, rvalid 3 cycles later → stale data never appears on issue. The next request has addr 0x200; the offer is issue = 01, in2_pc = 0x204, in2_npc = 0x208.
- branch_flag in the same cycle as a handover edge → that handover does not count and issue = 00 next cycle. The next request goes to the target.
- Assert rst while in S_WAIT, then return rvalid → data ignored; the first request after reset uses RESET_PC; all outputs read 0 during reset.
- fetch_pc = 0xFFFF_FFF8 → offer has in2_npc = 0x0000_0000 and the next imem_addr = 0x0000_0000.
